// File: rtl/host_bus_arbiter.sv
// Two-master arbiter/sequencer serialising single-beat reads and writes onto the shared bus.
// Define ARB_HOST_PRIORITY_EN for fixed priority to master 0 (PCIe host) instead of round-robin.
module host_bus_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_we,
    output logic              bus_re,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic [1:0]        grant,
    output logic              busy
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic                bus_we_q, bus_we_d;
    logic                bus_re_q, bus_re_d;
    logic [1:0]          grant_q, grant_d;
    logic                busy_q, busy_d;
    logic                m0_ack_q, m0_ack_d;
    logic                m1_ack_q, m1_ack_d;
    logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
    logic                pick_m1;

`ifdef ARB_HOST_PRIORITY_EN
    // Host always wins a tie; master 1 only gets the bus when master 0 is silent.
    assign pick_m1 = m1_req & ~m0_req;
`else
    // last_m1 set means master 1 was granted last, so master 0 wins the next tie.
    logic last_m1_q, last_m1_d;
    assign pick_m1 = m1_req & (~m0_req | ~last_m1_q);
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        we_d        = we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_we_d    = 1'b0;
        bus_re_d    = 1'b0;
        grant_d     = grant_q;
        m0_ack_d    = 1'b0;
        m1_ack_d    = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
`ifndef ARB_HOST_PRIORITY_EN
        last_m1_d   = last_m1_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    owner_d     = pick_m1;
                    we_d        = pick_m1 ? m1_we : m0_we;
                    bus_addr_d  = pick_m1 ? m1_addr : m0_addr;
                    bus_wdata_d = pick_m1 ? m1_wdata : m0_wdata;
                    bus_we_d    = we_d;
                    bus_re_d    = ~we_d;
                    grant_d     = pick_m1 ? 2'b10 : 2'b01;
`ifndef ARB_HOST_PRIORITY_EN
                    last_m1_d   = pick_m1;
`endif
                    state_d     = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (we_q) begin
                    m0_ack_d = ~owner_q;
                    m1_ack_d = owner_q;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d   = CNT_W'(RD_LATENCY);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Counter reaches 1 in the cycle the slave drives valid read data.
                if (cnt_q == CNT_W'(1)) begin
                    if (owner_q) begin
                        m1_rdata_d = bus_rdata;
                    end else begin
                        m0_rdata_d = bus_rdata;
                    end
                    m0_ack_d = ~owner_q;
                    m1_ack_d = owner_q;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_we_q    <= 1'b0;
            bus_re_q    <= 1'b0;
            grant_q     <= 2'b00;
            busy_q      <= 1'b0;
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
`ifndef ARB_HOST_PRIORITY_EN
            last_m1_q   <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_we_q    <= bus_we_d;
            bus_re_q    <= bus_re_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            m0_ack_q    <= m0_ack_d;
            m1_ack_q    <= m1_ack_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
`ifndef ARB_HOST_PRIORITY_EN
            last_m1_q   <= last_m1_d;
`endif
        end
    end

    assign m0_ack    = m0_ack_q;
    assign m1_ack    = m1_ack_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_we    = bus_we_q;
    assign bus_re    = bus_re_q;
    assign grant     = grant_q;
    assign busy      = busy_q;

endmodule
